// File: rtl/pmul_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pmul_pkg : op/state encodings and lane geometry for the packed multiply unit
// Rev 1.0
// ----------------------------------------------------------------------------
package pmul_pkg;

  localparam logic [1:0] PMUL_S16 = 2'b00;
  localparam logic [1:0] PMUL_U16 = 2'b01;
  localparam logic [1:0] PMUL_S8  = 2'b10;
  localparam logic [1:0] PMUL_U8  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int LANE_W16 = 16;
  localparam int LANE_W8  = 8;
  localparam int LANES16  = 2;
  localparam int LANES8   = 4;

  function automatic logic is_8bit(input logic [1:0] op);
    logic r;
    case (op)
      PMUL_S8, PMUL_U8:   r = 1'b1;
      PMUL_S16, PMUL_U16: r = 1'b0;
      default:            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] last_lane(input logic [1:0] op);
    return is_8bit(op) ? 2'(LANES8 - 1) : 2'(LANES16 - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_mul.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lane_mul : one 16- or 8-bit lane multiply on a shared 17x17 signed multiplier
// Rev 1.0
// ----------------------------------------------------------------------------
module lane_mul
  import pmul_pkg::*;
(
  input  logic [LANE_W16-1:0] a_i,
  input  logic [LANE_W16-1:0] b_i,
  input  logic                is8_i,
  input  logic                uns_i,
  output logic [LANE_W16-1:0] res_o,
  output logic                ovf_o
);

  logic signed [16:0] ax;
  logic signed [16:0] bx;
  logic signed [33:0] p;

  // The 17th bit turns unsigned operands into non-negative signed values.
  always_comb begin
    if (is8_i) begin
      ax = {{9{~uns_i & a_i[LANE_W8-1]}}, a_i[LANE_W8-1:0]};
      bx = {{9{~uns_i & b_i[LANE_W8-1]}}, b_i[LANE_W8-1:0]};
    end else begin
      ax = {~uns_i & a_i[LANE_W16-1], a_i};
      bx = {~uns_i & b_i[LANE_W16-1], b_i};
    end
  end

  assign p     = ax * bx;
  assign res_o = p[15:0];

  // Checking up to bit 33 is equivalent to the 2W-bit rule since p never exceeds it.
  always_comb begin
    if (is8_i) begin
      ovf_o = uns_i ? (p[33:8] != '0) : !((&p[33:7]) || !(|p[33:7]));
    end else begin
      ovf_o = uns_i ? (p[33:16] != '0) : !((&p[33:15]) || !(|p[33:15]));
    end
  end

endmodule
`default_nettype wire

// File: rtl/pmul_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pmul_sequencer : one-lane-per-cycle packed multiply sequencer with pipeline stall
// Rev 1.0
// ----------------------------------------------------------------------------
module pmul_sequencer
  import pmul_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  ovf
);

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  ovf_acc_q, ovf_acc_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  ovf_q, ovf_d;

  logic                  lane8;
  logic [LANE_W16-1:0]   la, lb, lres;
  logic                  lovf;

  assign lane8 = is_8bit(op_q);

  always_comb begin
    la = '0;
    lb = '0;
    if (lane8) begin
      la[LANE_W8-1:0] = a_q[{cnt_q, 3'b000} +: LANE_W8];
      lb[LANE_W8-1:0] = b_q[{cnt_q, 3'b000} +: LANE_W8];
    end else begin
      la = a_q[{cnt_q[0], 4'b0000} +: LANE_W16];
      lb = b_q[{cnt_q[0], 4'b0000} +: LANE_W16];
    end
  end

  lane_mul u_lane_mul (
    .a_i   (la),
    .b_i   (lb),
    .is8_i (lane8),
    .uns_i (op_q[0]),
    .res_o (lres),
    .ovf_o (lovf)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    ovf_acc_d = ovf_acc_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          if (lane8) acc_d[{cnt_q, 3'b000} +: LANE_W8] = lres[LANE_W8-1:0];
          else       acc_d[{cnt_q[0], 4'b0000} +: LANE_W16] = lres;
          ovf_acc_d = ovf_acc_q | lovf;
          cnt_d     = cnt_q + 2'd1;
          // Publish on the last lane so res/ovf only move at DONE entry.
          if (cnt_q == last_lane(op_q)) begin
            state_d = ST_DONE;
            res_d   = acc_d;
            ovf_d   = ovf_acc_d;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (start && !flush) begin
          state_d   = ST_MUL;
          op_d      = op;
          a_d       = a;
          b_d       = b;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = 2'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      ovf_acc_q <= ovf_acc_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy  = (state_q == ST_MUL);
  assign done  = (state_q == ST_DONE);
  assign stall = (start && (state_q == ST_IDLE || state_q == ST_DONE)) || busy;
  assign res   = res_q;
  assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pmul_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pmul_sequencer : directed-vector bench for the packed multiply sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pmul_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, stall, done, ovf;
  logic [31:0] res;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pmul_sequencer #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .res   (res),
    .ovf   (ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle and returns in the DONE cycle (or after a bound).
  task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                        output int stalls, output bit got);
    op = o; a = va; b = vb; start = 1'b1;
    #1;
    stalls = 0;
    got    = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (stall) stalls++;
      step();
      start = 1'b0;
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    #2;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (res !== 32'h0) begin n_err++; $display("FAIL reset_res: got %h want 00000000", res); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_u16();
    int st; bit got;
    run_op(2'b01, 32'h00030005, 32'h00040006, st, got);
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL u16_timeout: done got %b want 1", got); end
    n_vec++; if (st != 3) begin n_err++; $display("FAIL u16_stall_cycles: got %0d want 3", st); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL u16_stall_in_done: got %b want 0", stall); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL u16_busy_in_done: got %b want 0", busy); end
    n_vec++; if (res !== 32'h000C001E) begin n_err++; $display("FAIL u16_res: got %h want 000C001E", res); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL u16_ovf: got %b want 0", ovf); end
    step();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL u16_done_pulse: got %b want 0", done); end
    n_vec++; if (res !== 32'h000C001E) begin n_err++; $display("FAIL u16_res_hold: got %h want 000C001E", res); end
  endtask

  task automatic test_u8();
    int st; bit got;
    run_op(2'b11, 32'h02030405, 32'h02020202, st, got);
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL u8_timeout: done got %b want 1", got); end
    n_vec++; if (st != 5) begin n_err++; $display("FAIL u8_stall_cycles: got %0d want 5", st); end
    n_vec++; if (res !== 32'h0406080A) begin n_err++; $display("FAIL u8_res: got %h want 0406080A", res); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL u8_ovf: got %b want 0", ovf); end
    step();
  endtask

  task automatic test_ovf();
    logic [1:0]  t_op  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] t_a   [4] = '{32'hFFFF0002, 32'hFFFF0002, 32'h00000040, 32'h00000040};
    logic [31:0] t_b   [4] = '{32'h0003FFFD, 32'h0003FFFD, 32'h00000002, 32'h00000002};
    logic [31:0] t_res [4] = '{32'hFFFDFFFA, 32'hFFFDFFFA, 32'h00000080, 32'h00000080};
    logic        t_ovf [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int st; bit got;
    for (int i = 0; i < 4; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], st, got);
      n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL ovf%0d_timeout: done got %b want 1", i, got); end
      n_vec++; if (res !== t_res[i]) begin n_err++; $display("FAIL ovf%0d_res: got %h want %h", i, res, t_res[i]); end
      n_vec++; if (ovf !== t_ovf[i]) begin n_err++; $display("FAIL ovf%0d_ovf: got %b want %b", i, ovf, t_ovf[i]); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    bit got = 1'b0;
    op = 2'b01; a = 32'h00020002; b = 32'h00030003; start = 1'b1;
    #1;
    for (int k = 0; k < 12; k++) begin
      if (done) begin got = 1'b1; break; end
      step();
    end
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL b2b_first_timeout: done got %b want 1", got); end
    n_vec++; if (res !== 32'h00060006) begin n_err++; $display("FAIL b2b_first_res: got %h want 00060006", res); end
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall_in_done: got %b want 1", stall); end
    step();
    // Second op is in flight; new operands and a held start must not disturb it.
    a = 32'hFFFFFFFF;
    #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_no_idle: busy got %b want 1", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_mul_done: got %b want 0", done); end
    step();
    start = 1'b0;
    step();
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_second_done: got %b want 1", done); end
    n_vec++; if (res !== 32'h00060006) begin n_err++; $display("FAIL b2b_second_res: got %h want 00060006", res); end
    step();
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_extra_done: got %b want 0", done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_extra_busy: got %b want 0", busy); end
    a = 32'h0;
  endtask

  task automatic test_flush();
    int st; bit got; int ndone;
    run_op(2'b01, 32'h12345678, 32'h00010001, st, got);
    n_vec++; if (res !== 32'h12345678) begin n_err++; $display("FAIL flush_setup_res: got %h want 12345678", res); end
    step();
    op = 2'b11; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    step();
    start = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b want 0", busy); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", stall); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL flush_done: got %b want 0", done); end
    n_vec++; if (res !== 32'h12345678) begin n_err++; $display("FAIL flush_res: got %h want 12345678", res); end
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done) ndone++;
    end
    n_vec++; if (ndone != 0) begin n_err++; $display("FAIL flush_late_done: got %0d pulses want 0", ndone); end
    start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_beats_start: busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_op();
    op = 2'b11; a = 32'h01010101; b = 32'h01010101; start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_busy: got %b want 1", busy); end
    #1;
    rst = 1'b1;
    #1;
    n_vec++; if (res !== 32'h0) begin n_err++; $display("FAIL rstmid_res: got %h want 00000000", res); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rstmid_stall: got %b want 0", stall); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b want 0", done); end
    step();
    rst = 1'b0;
    step();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_after_busy: got %b want 0", busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_u16();
    test_u8();
    test_ovf();
    test_back_to_back();
    test_flush();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pmul_sequencer.md
Name: pmul_sequencer

Overview:
Multi-cycle sequencer for the packed (P-type) multiply ops in the execute stage. It time-multiplexes one 16x16 multiplier across the SIMD lanes of a 32-bit operand pair, one lane per cycle. While it works it stalls the pipeline through the hazard unit. The single-cycle ALU keeps all other ops; the decoder routes packed multiplies here instead.

Parameters:
DATA_WIDTH, 32, operand/result width; only 32 is supported (2x16 or 4x8 lanes).

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a packed multiply this cycle
op  input  2  00 signed 2x16, 01 unsigned 2x16, 10 signed 4x8, 11 unsigned 4x8
a  input  DATA_WIDTH  operand A (execute-stage forwarded value)
b  input  DATA_WIDTH  operand B
flush  input  1  abort the in-flight op (branch mispredict/trap)
busy  output  1  high while state is MUL
stall  output  1  freeze IF/ID/EX pipeline registers
done  output  1  one-cycle pulse; res/ovf valid
res  output  DATA_WIDTH  packed lane products
ovf  output  1  some lane product did not fit its lane under the selected signedness

Behaviour:
- Reset (async, any time, including mid-op):
  - state=IDLE, lane counter=0, res=0, ovf=0, done=0, busy=0.
  - stall=0 unless start is asserted while reset is held low.
- States: IDLE, MUL, DONE.
- Accepting a request:
  - IDLE or DONE with start=1 at an edge: latch a, b and op; clear the internal accumulator and ovf_acc; cnt=0; go to MUL.
  - start in MUL is ignored; the requester is stalled anyway.
- MUL, one lane per cycle, lane index = cnt:
  - Lane count N = 2 for 16-bit ops, 4 for 8-bit ops. Lane i occupies bits [i*W+W-1 : i*W], W = 16 or 8.
  - Product = full 2W-bit product of the lane operands, sign-extended when op[0]=0 and zero-extended when op[0]=1.
  - Lane result = low W bits of the product, written into the accumulator lane i.
  - ovf_acc |= product not representable in W bits:
    - signed: upper W+1 bits of the product are not all equal;
    - unsigned: upper W bits are not zero.
  - cnt increments each cycle; at cnt==N-1 the next state is DONE.
  - No wrap-around: cnt resets to 0 on every accept.
- DONE, exactly one cycle:
  - done=1; res=accumulator and ovf=ovf_acc are registered and stable this cycle.
  - Then IDLE, or MUL if start=1.
- res and ovf hold their values until the next DONE; they never change mid-op.
- Latency: request accepted at edge T, done high in cycle T+N+1, i.e. 3 cycles after accept for 16-bit ops and 5 for 8-bit ops.
- stall = (start & (state==IDLE | state==DONE)) | (state==MUL). It is combinational, so the requesting instruction holds in EX. stall is low in the DONE cycle unless a back-to-back start occurs, so the pipeline captures res on that edge.
- flush:
  - In MUL: next state IDLE; no done; res/ovf keep old values; the accumulator is discarded.
  - In IDLE/DONE with start: no accept; flush has priority over start.
  - flush and start in the same cycle while in MUL: flush wins; the start is dropped.
- No combinational path from a/b to res; all arithmetic is performed on the latched operands.

Decomposition:
- Shared package pmul_pkg:
  - op encodings PMUL_S16, PMUL_U16, PMUL_S8, PMUL_U8;
  - state encoding ST_IDLE, ST_MUL, ST_DONE;
  - lane widths and lane-count constants.
- One sub-module, lane_mul:
  - combinational 17x17 signed multiply;
  - inputs: W-bit lane operands, lane-width select and signedness;
  - outputs: W-bit low result and the overflow bit.
- The 8-bit case reuses the 16-bit multiplier with extended operands.

Test Plan:
- op=01, a=0x00030005, b=0x00040006, start one cycle -> stall 3 cycles (accept + 2 MUL), done in cycle 3 after accept, res=0x000C001E, ovf=0.
- op=11, a=0x02030405, b=0x02020202 -> 4 MUL cycles, done at T+5, res=0x0406080A, ovf=0.
- op=00, a=0xFFFF0002, b=0x0003FFFD -> res=0xFFFDFFFA (-3,-6), ovf=0; same operands with op=01 -> res=0xFFFDFFFA, ovf=1.
- op=10, a=0x00000040, b=0x00000002 -> res=0x00000080, ovf=1; op=11 same operands -> res=0x00000080, ovf=0.
- Back-to-back starts: start held through DONE of op=01 (a=0x00020002, b=0x00030003) -> done pulses twice, res=0x00060006 each time, no idle cycle between; a start pulsed during MUL does not create an extra done.
- Abort cases:
  - prior res=0x12345678; start op=11, flush in the 2nd MUL cycle -> next cycle busy=0, stall=0, no done, res=0x12345678;
  - repeat with rst asserted mid-MUL -> res=0, busy=0 immediately (async).
